cam_axi_wr_arbiter: RTL and testbench

- Shares one AXI3 master write port (AW/W/B) between two burst-write requesters, e.g. the capture VRAM controller and a second DMA engine.
- Grants whole bursts round-robin and generates WLAST from a beat counter.
- Tracks outstanding write responses in order and routes each B response back to the requester that issued it.
- Sits between the requesters and the M_AXI write signals at the top level.

---
 rtl/cam_axi_wr_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_cam_axi_wr_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_axi_wr_arbiter.sv
// cam_axi_wr_arbiter
// Shares one AXI3 master write port (AW/W/B) between two burst-write
// requesters. Whole bursts are granted round-robin, WLAST comes from a local
// beat counter, and a small in-order FIFO of requester IDs routes each B
// response back to the requester whose burst it completes.
//
// Ports:
//   ACLK, ARST               clock (rising edge), asynchronous active-high reset
//   REQn_AWADDR/AWVALID      burst start address / request from requester n
//   REQn_AWREADY             address accepted (granted requester only)
//   REQn_WDATA/WVALID        beat data / valid from requester n
//   REQn_WREADY              beat accepted (granted requester only)
//   REQn_BDONE               one-cycle pulse when requester n's response lands
//   M_AXI_*                  shared AXI3 write master (AW, W, B channels)
//   BUSY                     FSM not idle or responses still outstanding
//   BRESP_ERR                sticky flag, any non-OKAY write response seen
module cam_axi_wr_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int BURST_LEN       = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  ACLK,
  input  logic                  ARST,
  input  logic [ADDR_WIDTH-1:0] REQ0_AWADDR,
  input  logic                  REQ0_AWVALID,
  output logic                  REQ0_AWREADY,
  input  logic [DATA_WIDTH-1:0] REQ0_WDATA,
  input  logic                  REQ0_WVALID,
  output logic                  REQ0_WREADY,
  output logic                  REQ0_BDONE,
  input  logic [ADDR_WIDTH-1:0] REQ1_AWADDR,
  input  logic                  REQ1_AWVALID,
  output logic                  REQ1_AWREADY,
  input  logic [DATA_WIDTH-1:0] REQ1_WDATA,
  input  logic                  REQ1_WVALID,
  output logic                  REQ1_WREADY,
  output logic                  REQ1_BDONE,
  output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  output logic                  M_AXI_WLAST,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  output logic                  BUSY,
  output logic                  BRESP_ERR
);

  localparam int CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int FCNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [FCNT_W-1:0] FIFO_CAP  = FCNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0]  PTR_MAX   = PTR_W'(MAX_OUTSTANDING - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              grant_q, grant_d;
  // Requester granted most recently; reset to 1 so requester 0 wins the
  // first contended arbitration.
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [1:0]        bdone_q, bdone_d;
  logic              err_q, err_d;
  logic              id_fifo_q [MAX_OUTSTANDING];

  logic fifo_full, fifo_empty;
  logic wvalid_g;
  logic aw_hs, w_hs, last_hs;
  logic push, pop;

  always_comb begin
    fifo_full  = (fcnt_q == FIFO_CAP);
    fifo_empty = (fcnt_q == '0);
    wvalid_g   = grant_q ? REQ1_WVALID : REQ0_WVALID;
    aw_hs      = (state_q == ST_ADDR) && M_AXI_AWREADY;
    w_hs       = (state_q == ST_DATA) && wvalid_g && M_AXI_WREADY;
    last_hs    = w_hs && (cnt_q == LAST_BEAT);
    push       = last_hs;
    pop        = M_AXI_BVALID && !fifo_empty;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fcnt_d   = fcnt_q;
    bdone_d  = 2'b00;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        // A new burst is only started when its response has a FIFO slot.
        if (!fifo_full && (REQ0_AWVALID || REQ1_AWVALID)) begin
          if (REQ0_AWVALID && REQ1_AWVALID) begin
            grant_d = ~last_q;
          end else begin
            grant_d = REQ1_AWVALID;
          end
          last_d  = grant_d;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (aw_hs) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end
      end
      ST_DATA: begin
        if (w_hs) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (last_hs) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PTR_W'(1);
      bdone_d  = id_fifo_q[rd_ptr_q] ? 2'b10 : 2'b01;
      if (M_AXI_BRESP != 2'b00) begin
        err_d = 1'b1;
      end
    end
    // Simultaneous push and pop leave the occupancy unchanged.
    fcnt_d = fcnt_q + FCNT_W'(push) - FCNT_W'(pop);
  end

  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      state_q  <= ST_IDLE;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      bdone_q  <= 2'b00;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fcnt_q   <= fcnt_d;
      bdone_q  <= bdone_d;
      err_q    <= err_d;
    end
  end

  // ID storage carries no reset: occupancy is tracked by fcnt_q alone.
  always_ff @(posedge ACLK) begin
    if (push) begin
      id_fifo_q[wr_ptr_q] <= grant_q;
    end
  end

  always_comb begin
    M_AXI_AWADDR  = grant_q ? REQ1_AWADDR : REQ0_AWADDR;
    M_AXI_AWVALID = (state_q == ST_ADDR);
    M_AXI_WDATA   = grant_q ? REQ1_WDATA : REQ0_WDATA;
    M_AXI_WVALID  = (state_q == ST_DATA) && wvalid_g;
    M_AXI_WLAST   = (state_q == ST_DATA) && (cnt_q == LAST_BEAT);
    M_AXI_BREADY  = !fifo_empty;
    REQ0_AWREADY  = (state_q == ST_ADDR) && !grant_q && M_AXI_AWREADY;
    REQ1_AWREADY  = (state_q == ST_ADDR) &&  grant_q && M_AXI_AWREADY;
    REQ0_WREADY   = (state_q == ST_DATA) && !grant_q && M_AXI_WREADY;
    REQ1_WREADY   = (state_q == ST_DATA) &&  grant_q && M_AXI_WREADY;
    REQ0_BDONE    = bdone_q[0];
    REQ1_BDONE    = bdone_q[1];
    BUSY          = (state_q != ST_IDLE) || !fifo_empty;
    BRESP_ERR     = err_q;
  end

endmodule

// File: tb/tb_cam_axi_wr_arbiter.sv
// Directed bench for cam_axi_wr_arbiter: requester tasks drive bursts, a
// negedge monitor logs bus events, and each test task checks the logs.
module tb_cam_axi_wr_arbiter;
  localparam int BL = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req_awaddr [2];
  logic [63:0] req_wdata  [2];
  logic [1:0]  req_awvalid, req_wvalid;
  wire  [1:0]  req_awready, req_wready, req_bdone;
  logic [31:0] m_awaddr;
  logic        m_awvalid, m_awready;
  logic [63:0] m_wdata;
  logic        m_wvalid, m_wready, m_wlast;
  logic [1:0]  m_bresp;
  logic        m_bvalid, m_bready;
  logic        busy, bresp_err;

  int total = 0;
  int bad   = 0;
  bit abort = 0;

  int          grant_log [$];
  int          bdone_log [$];
  int          last_log  [$];
  logic [31:0] addr_log  [$];
  logic [63:0] wdata_log [$];
  int awv_cycles, beats_total, cur_beats, req1_seen, wlast_bad, wlast_stall;
  int bd_run, bd_max;

  always #5 clk = ~clk;

  cam_axi_wr_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .BURST_LEN(BL), .MAX_OUTSTANDING(4)) dut (
    .ACLK(clk), .ARST(rst),
    .REQ0_AWADDR(req_awaddr[0]), .REQ0_AWVALID(req_awvalid[0]), .REQ0_AWREADY(req_awready[0]),
    .REQ0_WDATA(req_wdata[0]), .REQ0_WVALID(req_wvalid[0]), .REQ0_WREADY(req_wready[0]),
    .REQ0_BDONE(req_bdone[0]),
    .REQ1_AWADDR(req_awaddr[1]), .REQ1_AWVALID(req_awvalid[1]), .REQ1_AWREADY(req_awready[1]),
    .REQ1_WDATA(req_wdata[1]), .REQ1_WVALID(req_wvalid[1]), .REQ1_WREADY(req_wready[1]),
    .REQ1_BDONE(req_bdone[1]),
    .M_AXI_AWADDR(m_awaddr), .M_AXI_AWVALID(m_awvalid), .M_AXI_AWREADY(m_awready),
    .M_AXI_WDATA(m_wdata), .M_AXI_WVALID(m_wvalid), .M_AXI_WREADY(m_wready),
    .M_AXI_WLAST(m_wlast), .M_AXI_BRESP(m_bresp), .M_AXI_BVALID(m_bvalid),
    .M_AXI_BREADY(m_bready), .BUSY(busy), .BRESP_ERR(bresp_err)
  );

  function automatic logic [63:0] wd(input int id, input int b, input int k);
    return {16'hC0DE, 16'(id), 16'(b), 16'(k)};
  endfunction

  task automatic clear_logs();
    grant_log.delete(); bdone_log.delete(); last_log.delete();
    addr_log.delete(); wdata_log.delete();
    awv_cycles = 0; beats_total = 0; cur_beats = 0; req1_seen = 0;
    wlast_bad = 0; wlast_stall = 0; bd_run = 0; bd_max = 0;
  endtask

  // Bus monitor: values at the falling edge describe the coming rising edge.
  initial begin
    clear_logs();
    forever begin
      @(negedge clk);
      if (m_awvalid) awv_cycles++;
      if (m_awvalid && m_awready) begin
        grant_log.push_back(req_awready[1] ? 1 : (req_awready[0] ? 0 : 9));
        addr_log.push_back(m_awaddr);
        cur_beats = 0;
      end
      if (req_awready[1] || req_wready[1]) req1_seen++;
      if (m_wlast && !m_wvalid) wlast_bad++;
      if (m_wlast && m_wvalid && !m_wready) wlast_stall++;
      if (m_wvalid && m_wready) begin
        beats_total++;
        cur_beats++;
        wdata_log.push_back(m_wdata);
        if (m_wlast) last_log.push_back(cur_beats);
      end
      if (req_bdone[0]) bdone_log.push_back(0);
      if (req_bdone[1]) bdone_log.push_back(1);
      if (req_bdone != 2'b00) bd_run++; else bd_run = 0;
      if (bd_run > bd_max) bd_max = bd_run;
    end
  end

  task automatic req_burst(input int id, input logic [31:0] base, input int n);
    int t;
    bit hs;
    for (int b = 0; b < n; b++) begin
      req_awaddr[id]  = base + 32'(b) * 32'h100;
      req_awvalid[id] = 1'b1;
      hs = 0; t = 0;
      while (!hs && !abort && t < 400) begin
        @(negedge clk); hs = req_awready[id]; @(posedge clk); #1; t++;
      end
      req_awvalid[id] = 1'b0;
      if (!hs) begin
        if (!abort) begin
          total++; bad++;
          $display("FAIL aw_timeout req%0d burst%0d: got no AWREADY in %0d cycles, required one", id, b, t);
        end
        return;
      end
      for (int k = 0; k < BL; k++) begin
        req_wdata[id]  = wd(id, b, k);
        req_wvalid[id] = 1'b1;
        hs = 0; t = 0;
        while (!hs && !abort && t < 400) begin
          @(negedge clk); hs = req_wready[id]; @(posedge clk); #1; t++;
        end
        if (!hs) begin
          req_wvalid[id] = 1'b0;
          if (!abort) begin
            total++; bad++;
            $display("FAIL w_timeout req%0d burst%0d beat%0d: got no WREADY, required one", id, b, k);
          end
          return;
        end
      end
      req_wvalid[id] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++;
    if ({m_awvalid, m_wvalid, m_wlast, m_bready, req_bdone, busy, bresp_err} !== 8'h00) begin
      bad++;
      $display("FAIL reset_ctrl: got %b required 00000000",
               {m_awvalid, m_wvalid, m_wlast, m_bready, req_bdone, busy, bresp_err});
    end
    total++;
    if ({req_awready, req_wready} !== 4'h0) begin
      bad++; $display("FAIL reset_ready: got %b required 0000", {req_awready, req_wready});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
    // Stray BVALID with nothing outstanding must be ignored.
    m_bvalid = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if ({m_bready, busy} !== 2'b00 || bdone_log.size() != 0) begin
      bad++;
      $display("FAIL idle_bvalid: got bready/busy=%b bdones=%0d required 00 and 0", {m_bready, busy}, bdone_log.size());
    end
  endtask

  task automatic test_single();
    do_reset();
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1; m_bresp = 2'b00;
    req_burst(0, 32'h2000_0000, 1);
    for (int t = 0; t < 50 && bdone_log.size() < 1; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    total++;
    if (awv_cycles != 1) begin bad++; $display("FAIL single_awv_cycles: got %0d required 1", awv_cycles); end
    total++;
    if (grant_log.size() != 1 || addr_log[0] !== 32'h2000_0000) begin
      bad++; $display("FAIL single_aw: got %0d grants addr %h required 1 grant addr 20000000", grant_log.size(), addr_log[0]);
    end
    total++;
    if (beats_total != BL || last_log.size() != 1 || last_log[0] != BL) begin
      bad++; $display("FAIL single_beats: got %0d beats wlast_count=%0d required %0d beats with WLAST on beat %0d", beats_total, last_log.size(), BL, BL);
    end
    total++;
    if (wdata_log.size() != BL || wdata_log[BL-1] !== wd(0, 0, BL-1)) begin
      bad++; $display("FAIL single_wdata: got %0d beats, required %0d beats ending %h", wdata_log.size(), BL, wd(0, 0, BL-1));
    end
    total++;
    if (bdone_log.size() != 1 || bdone_log[0] != 0 || bd_max != 1) begin
      bad++; $display("FAIL single_bdone: got %0d pulses width %0d required 1 pulse on req0 width 1", bdone_log.size(), bd_max);
    end
    total++;
    if (req1_seen != 0) begin bad++; $display("FAIL single_req1_ready: got %0d cycles required 0", req1_seen); end
    total++;
    if ({busy, m_bready} !== 2'b00) begin bad++; $display("FAIL single_idle_after: got busy/bready=%b required 00", {busy, m_bready}); end
  endtask

  task automatic test_alternate();
    do_reset();
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1;
    fork
      req_burst(0, 32'h1000_0000, 2);
      req_burst(1, 32'h4000_0000, 2);
    join
    for (int t = 0; t < 50 && bdone_log.size() < 4; t++) @(negedge clk);
    total++;
    if (grant_log.size() != 4 || bdone_log.size() != 4) begin
      bad++; $display("FAIL alt_counts: got %0d grants %0d bdones required 4 and 4", grant_log.size(), bdone_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (grant_log[i] != (i % 2) || bdone_log[i] != (i % 2)) begin
          bad++; $display("FAIL alt_order[%0d]: got grant %0d bdone %0d required %0d", i, grant_log[i], bdone_log[i], i % 2);
        end
      end
    end
  endtask

  task automatic test_wready_toggle();
    logic [3:0] pat;
    do_reset();
    pat = 4'b1001;
    m_awready = 1'b1; m_bvalid = 1'b1;
    fork
      req_burst(0, 32'h2000_0000, 1);
      for (int i = 0; i < 60 && beats_total < BL; i++) begin
        m_wready = pat[3 - (i % 4)];
        @(posedge clk); #1;
      end
    join
    m_wready = 1'b1;
    for (int t = 0; t < 50 && bdone_log.size() < 1; t++) @(negedge clk);
    total++;
    if (beats_total != BL || last_log.size() != 1 || last_log[0] != BL) begin
      bad++; $display("FAIL toggle_beats: got %0d beats, required %0d with WLAST on the last", beats_total, BL);
    end
    total++;
    if (wlast_bad != 0) begin bad++; $display("FAIL toggle_wlast_without_wvalid: got %0d cycles required 0", wlast_bad); end
    for (int k = 0; k < BL; k++) begin
      total++;
      if (k >= wdata_log.size() || wdata_log[k] !== wd(0, 0, k)) begin
        bad++; $display("FAIL toggle_wdata[%0d]: required %h", k, wd(0, 0, k));
      end
    end
  endtask

  task automatic test_outstanding();
    bit seen;
    do_reset();
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0;
    fork
      req_burst(0, 32'h5000_0000, 5);
      begin
        for (int t = 0; t < 300 && grant_log.size() < 4; t++) @(negedge clk);
        repeat (14) @(negedge clk);
        total++;
        if (grant_log.size() != 4 || awv_cycles != 4) begin
          bad++; $display("FAIL full_blocks: got %0d grants %0d AWVALID cycles required 4 and 4", grant_log.size(), awv_cycles);
        end
        total++;
        if ({m_awvalid, m_bready, busy} !== 3'b011) begin
          bad++; $display("FAIL full_state: got awvalid/bready/busy=%b required 011", {m_awvalid, m_bready, busy});
        end
        @(posedge clk); #1 m_bvalid = 1'b1;
        @(posedge clk); #1 m_bvalid = 1'b0;
        seen = 0;
        for (int t = 0; t < 2 && !seen; t++) begin
          @(negedge clk);
          if (m_awvalid) seen = 1;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL full_release: got no AWVALID within 2 cycles, required one"); end
        total++;
        if (bdone_log.size() != 1) begin bad++; $display("FAIL full_one_pop: got %0d bdones required 1", bdone_log.size()); end
        m_bvalid = 1'b1;
      end
    join
    for (int t = 0; t < 50 && bdone_log.size() < 5; t++) @(negedge clk);
    total++;
    if (bdone_log.size() != 5 || grant_log.size() != 5) begin
      bad++; $display("FAIL full_drain: got %0d bdones %0d grants required 5 and 5", bdone_log.size(), grant_log.size());
    end
  endtask

  task automatic test_bresp_err();
    do_reset();
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1; m_bresp = 2'b10;
    req_burst(0, 32'h6000_0000, 1);
    for (int t = 0; t < 50 && bdone_log.size() < 1; t++) @(negedge clk);
    m_bresp = 2'b00;
    @(negedge clk);
    total++;
    if (bresp_err !== 1'b1) begin bad++; $display("FAIL bresp_set: got %b required 1", bresp_err); end
    req_burst(1, 32'h6100_0000, 1);
    for (int t = 0; t < 50 && bdone_log.size() < 2; t++) @(negedge clk);
    @(negedge clk);
    total++;
    if (bresp_err !== 1'b1 || bdone_log.size() != 2 || bdone_log[1] != 1) begin
      bad++; $display("FAIL bresp_sticky: got err=%b bdones=%0d required err=1 with second pulse on req1", bresp_err, bdone_log.size());
    end
    rst = 1'b1;
    #1;
    total++;
    if (bresp_err !== 1'b0) begin bad++; $display("FAIL bresp_clear: got %b required 0", bresp_err); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1; m_bresp = 2'b00;
    fork
      req_burst(0, 32'h7000_0000, 1);
      begin
        for (int t = 0; t < 100 && beats_total < 3; t++) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({m_awvalid, m_wvalid, m_wlast, m_bready, req_bdone, busy, bresp_err, req_wready} !== 10'h000) begin
          bad++;
          $display("FAIL midburst_reset: got %b required 0000000000",
                   {m_awvalid, m_wvalid, m_wlast, m_bready, req_bdone, busy, bresp_err, req_wready});
        end
        abort = 1;
      end
    join
    @(posedge clk); #1 rst = 1'b0;
    abort = 0;
    clear_logs();
    req_burst(1, 32'h7100_0000, 1);
    for (int t = 0; t < 50 && bdone_log.size() < 1; t++) @(negedge clk);
    total++;
    if (grant_log.size() != 1 || grant_log[0] != 1 || addr_log[0] !== 32'h7100_0000) begin
      bad++; $display("FAIL post_reset_grant: got %0d grants, required one grant to req1 at 71000000", grant_log.size());
    end
    total++;
    if (beats_total != BL || last_log.size() != 1 || last_log[0] != BL || wdata_log[0] !== wd(1, 0, 0)) begin
      bad++; $display("FAIL post_reset_beats: got %0d beats, required %0d with WLAST on beat %0d", beats_total, BL, BL);
    end
    total++;
    if (bdone_log.size() != 1 || bdone_log[0] != 1) begin
      bad++; $display("FAIL post_reset_bdone: got %0d pulses, required one on req1", bdone_log.size());
    end
  endtask

  initial begin
    rst = 1'b0;
    req_awaddr[0] = '0; req_awaddr[1] = '0;
    req_wdata[0]  = '0; req_wdata[1]  = '0;
    req_awvalid = 2'b00; req_wvalid = 2'b00;
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0; m_bresp = 2'b00;
    test_reset();
    test_single();
    test_alternate();
    test_wready_toggle();
    test_outstanding();
    test_bresp_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
